// File: rtl/hazard_controller_if.sv
// Hazard controller interface: pipeline hazard inputs and stall/flush outputs.
// master = pipeline side driving hazard sources, slave = hazard_controller.
interface hazard_controller_if;
    logic [4:0]  idRs;
    logic [4:0]  idRt;
    logic        exMemRead;
    logic [4:0]  exRt;
    logic        branchTaken;
    logic        mcStart;
    logic        hazard;
    logic        ifFlush;
    logic        idExBubble;
    logic        exHold;
    logic        mcBusy;
    logic [31:0] stallCount;
    logic [31:0] flushCount;

    modport master (
        output idRs, idRt, exMemRead, exRt, branchTaken, mcStart,
        input  hazard, ifFlush, idExBubble, exHold, mcBusy, stallCount, flushCount
    );

    modport slave (
        input  idRs, idRt, exMemRead, exRt, branchTaken, mcStart,
        output hazard, ifFlush, idExBubble, exHold, mcBusy, stallCount, flushCount
    );
endinterface

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use, branch flush, multi-cycle EX hold.
// Optional macro HAZARD_STATS_EN adds free-running stall/flush cycle counters.
module hazard_controller #(
    parameter int unsigned MC_LATENCY = 4
) (
    input  logic               clk,
    input  logic               reset,
    hazard_controller_if.slave bus
);
    typedef enum logic {RUN, MC_STALL} state_e;

    localparam logic [3:0] MC_RELOAD = 4'(MC_LATENCY - 2);

    state_e     state_q, state_d;
    logic [3:0] mc_cnt_q, mc_cnt_d;
    logic       load_use;
    logic       hazard_c, if_flush_c, bubble_c, ex_hold_c, mc_busy_c;

    assign load_use = bus.exMemRead && (bus.exRt != 5'd0) &&
                      ((bus.exRt == bus.idRs) || (bus.exRt == bus.idRt));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RUN;
            mc_cnt_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mc_cnt_d   = mc_cnt_q;
        hazard_c   = 1'b0;
        if_flush_c = 1'b0;
        bubble_c   = 1'b0;
        ex_hold_c  = 1'b0;
        mc_busy_c  = 1'b0;
        // Outputs are forced low while reset is held, whatever the inputs request.
        if (!reset) begin
            unique case (state_q)
                RUN: begin
                    if (bus.mcStart) begin
                        hazard_c  = 1'b1;
                        ex_hold_c = 1'b1;
                        state_d   = MC_STALL;
                        mc_cnt_d  = MC_RELOAD;
                    end else if (load_use) begin
                        hazard_c = 1'b1;
                        bubble_c = 1'b1;
                    end else if (bus.branchTaken) begin
                        if_flush_c = 1'b1;
                    end
                end
                MC_STALL: begin
                    hazard_c  = 1'b1;
                    ex_hold_c = 1'b1;
                    mc_busy_c = 1'b1;
                    if (mc_cnt_q == 4'd0) begin
                        state_d = RUN;
                    end else begin
                        mc_cnt_d = mc_cnt_q - 4'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign bus.hazard     = hazard_c;
    assign bus.ifFlush    = if_flush_c;
    assign bus.idExBubble = bubble_c;
    assign bus.exHold     = ex_hold_c;
    assign bus.mcBusy     = mc_busy_c;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, hazard_c};
        flush_cnt_d = flush_cnt_q + {31'd0, if_flush_c};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stallCount = stall_cnt_q;
    assign bus.flushCount = flush_cnt_q;
`else
    assign bus.stallCount = 32'd0;
    assign bus.flushCount = 32'd0;
`endif
endmodule

// File: tb/tb_hazard_controller.sv
// Directed scoreboard bench for hazard_controller (MC_LATENCY=4); honours HAZARD_STATS_EN.
module tb_hazard_controller;
    logic clk;
    logic reset;

    hazard_controller_if bus ();

    hazard_controller #(.MC_LATENCY(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl = {hazard, ifFlush, idExBubble, exHold, mcBusy}
    typedef struct {
        string       name;
        logic [4:0]  ctrl;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_stall = 32'd0;
    logic [31:0] exp_flush = 32'd0;

    task automatic step(input string nm, input bit rst, input bit mrd,
                        input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                        input bit br, input bit mc, input logic [4:0] ctrl);
        exp_t e;
        @(posedge clk);
        #1;
        reset           = rst;
        bus.exMemRead   = mrd;
        bus.exRt        = ert;
        bus.idRs        = rs;
        bus.idRt        = rt;
        bus.branchTaken = br;
        bus.mcStart     = mc;
        e.name  = nm;
        e.ctrl  = ctrl;
`ifdef HAZARD_STATS_EN
        e.stall = exp_stall;
        e.flush = exp_flush;
        if (rst) begin
            exp_stall = 32'd0;
            exp_flush = 32'd0;
        end else begin
            exp_stall = exp_stall + {31'd0, ctrl[4]};
            exp_flush = exp_flush + {31'd0, ctrl[3]};
        end
`else
        e.stall = 32'd0;
        e.flush = 32'd0;
`endif
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [4:0] act;
            e   = sb.pop_front();
            act = {bus.hazard, bus.ifFlush, bus.idExBubble, bus.exHold, bus.mcBusy};
            checks++;
            if (act !== e.ctrl) begin
                errors++;
                $display("FAIL %s ctrl got %b expected %b", e.name, act, e.ctrl);
            end
            checks++;
            if (bus.stallCount !== e.stall) begin
                errors++;
                $display("FAIL %s stallCount got %0d expected %0d", e.name, bus.stallCount, e.stall);
            end
            checks++;
            if (bus.flushCount !== e.flush) begin
                errors++;
                $display("FAIL %s flushCount got %0d expected %0d", e.name, bus.flushCount, e.flush);
            end
        end
    end

    initial begin
        reset           = 1'b1;
        bus.exMemRead   = 1'b0;
        bus.exRt        = 5'd0;
        bus.idRs        = 5'd0;
        bus.idRt        = 5'd0;
        bus.branchTaken = 1'b0;
        bus.mcStart     = 1'b0;

        //    name          rst mrd exRt rs  rt  br mc  {haz,flu,bub,hold,busy}
        step("rst_a",        1, 0,  0,   0,  0,  1, 1, 5'b00000);
        step("rst_b",        1, 0,  0,   0,  0,  1, 1, 5'b00000);
        step("idle0",        0, 0,  0,   0,  0,  0, 0, 5'b00000);
        step("lu_rs",        0, 1,  8,   8,  3,  0, 0, 5'b10100);
        step("idle1",        0, 0,  8,   8,  3,  0, 0, 5'b00000);
        step("lu_rt",        0, 1,  9,   4,  9,  0, 0, 5'b10100);
        step("lu_r0",        0, 1,  0,   0,  0,  0, 0, 5'b00000);
        step("lu_nomr",      0, 0,  8,   8,  8,  0, 0, 5'b00000);
        step("lu_nomatch",   0, 1,  7,   6,  5,  0, 0, 5'b00000);
        step("branch",       0, 0,  0,   0,  0,  1, 0, 5'b01000);
        step("lu_vs_br",     0, 1,  8,   8,  0,  1, 0, 5'b10100);
        // Plain multi-cycle op.
        step("mc1",          0, 0,  0,   0,  0,  0, 1, 5'b10010);
        step("mc2",          0, 0,  0,   0,  0,  0, 0, 5'b10011);
        step("mc3",          0, 0,  0,   0,  0,  0, 0, 5'b10011);
        step("mc4",          0, 0,  0,   0,  0,  0, 0, 5'b10011);
        step("mc_done",      0, 0,  0,   0,  0,  0, 0, 5'b00000);
        // Multi-cycle op with load-use and branch pending; mcStart held through exit.
        step("pri1",         0, 1,  8,   8,  0,  1, 1, 5'b10010);
        step("pri2",         0, 1,  8,   8,  0,  1, 1, 5'b10011);
        step("pri3",         0, 1,  8,   8,  0,  1, 1, 5'b10011);
        step("pri4",         0, 1,  8,   8,  0,  1, 1, 5'b10011);
        step("pri5_flush",   0, 0,  0,   0,  0,  1, 0, 5'b01000);
        step("idle2",        0, 0,  0,   0,  0,  0, 0, 5'b00000);
        // Reset on the 2nd MC_STALL cycle aborts the stall.
        step("ab1",          0, 0,  0,   0,  0,  0, 1, 5'b10010);
        step("ab2",          0, 0,  0,   0,  0,  0, 0, 5'b10011);
        step("ab_rst",       1, 0,  0,   0,  0,  1, 0, 5'b00000);
        step("ab_after",     0, 0,  0,   0,  0,  0, 0, 5'b00000);
        step("re1",          0, 0,  0,   0,  0,  0, 1, 5'b10010);
        step("re2",          0, 0,  0,   0,  0,  0, 0, 5'b10011);
        step("re3",          0, 0,  0,   0,  0,  0, 0, 5'b10011);
        step("re4",          0, 0,  0,   0,  0,  0, 0, 5'b10011);
        step("re_done",      0, 0,  0,   0,  0,  0, 0, 5'b00000);
        step("br_end",       0, 0,  0,   0,  0,  1, 0, 5'b01000);
        step("idle3",        0, 0,  0,   0,  0,  0, 0, 5'b00000);

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain queue has %0d entries expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
